mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported unified memory between two requesters: the multicycle CPU
//  controller (instruction fetch, LW, SW, indirect loads) and the DMA/program loader.
//  Round-robin arbitration, registered address/data capture at grant, a configurable
//  memory wait-state counter, and a one-cycle ack pulse with registered read data.
//  Sits between the controller/datapath memory interface and the memory macro.
// PARAMETERS
//  AW       5  address width (bits)
//  DW       8  data width (bits)
//  MEM_LAT  1  memory access cycles per transfer, >=1; read data valid on last one
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous reset, active-low
//  cpu_req    in   1   CPU request; held until cpu_ack is seen
//  cpu_we     in   1   1=write, 0=read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_rdata  out  DW  CPU read data, valid while cpu_ack=1
//  cpu_ack    out  1   one-cycle pulse, CPU transfer complete
//  cpu_stall  out  1   cpu_req & ~cpu_ack (combinational), freezes controller state
//  dma_req/dma_we/dma_addr/dma_wdata in, dma_rdata/dma_ack out: same as CPU set
//  mem_addr   out  AW  memory address (registered)
//  mem_wdata  out  DW  memory write data (registered)
//  mem_rd     out  1   memory read strobe
//  mem_wr     out  1   memory write strobe
//  mem_rdata  in   DW  memory read data
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, all outputs 0 (cpu_stall follows cpu_req),
//    lat_cnt=0, last_grant=DMA so the CPU wins the first tie. Reset mid-access aborts
//    the transfer: strobes drop immediately, no ack is issued.
//  - States: IDLE -> ACC_CPU | ACC_DMA -> ACK -> IDLE.
//  - IDLE: sample cpu_req/dma_req. One requesting -> grant it. Both -> grant the one
//    not in last_grant. None -> stay. At the grant edge latch addr, wdata, we, owner;
//    update last_grant; lat_cnt=MEM_LAT-1.
//  - ACC_x: mem_addr/mem_wdata from latched regs; mem_rd=~we, mem_wr=we, held for
//    exactly MEM_LAT cycles. lat_cnt decrements each cycle; at lat_cnt==0 capture
//    mem_rdata (reads only) into the owner's rdata reg and go to ACK.
//  - ACK: owner's ack=1 for one cycle, strobes 0, rdata valid; other rdata unchanged.
//    Next state IDLE unconditionally (one idle/arb cycle between transfers).
//  - Latency: req seen in IDLE cycle 0 -> strobes cycles 1..MEM_LAT -> ack cycle
//    MEM_LAT+1. Min 3 cycles per transfer at MEM_LAT=1.
//  - Handshake: requester keeps req and fields stable until ack; drops req on the edge
//    it samples ack=1. req still high in IDLE after ACK is a new request. Changes on
//    req/addr/data during ACC_x/ACK are ignored (latched copy used).
//  - Simultaneous: a requester arriving during the other's transfer waits; next IDLE
//    grants it (round-robin) even if the previous owner re-requests.
//  - mem_rd and mem_wr never both 1; never asserted outside ACC_x.
//  - lat_cnt width = $clog2(MEM_LAT+1); no wrap, reloaded on every grant.
// TESTING
//  1 Reset: rst=0 with both req=1 -> all strobes/acks 0, state IDLE; release rst ->
//    CPU granted first, mem_rd=1 in cycle 1, cpu_ack in cycle 2 with MEM_LAT=1.
//  2 CPU read addr 5'h03, mem holds 8'hA5, MEM_LAT=1 -> mem_addr=03, mem_rd 1 cycle,
//    cpu_rdata=8'hA5 with cpu_ack on cycle 2; dma_ack stays 0.
//  3 DMA write addr 5'h1F data 8'h3C, MEM_LAT=3 -> mem_wr=1 for 3 cycles, mem_rd=0,
//    dma_ack pulse on cycle 4; cpu_stall=0 throughout (cpu_req=0).
//  4 Both req held continuously for 4 transfers -> grants alternate CPU,DMA,CPU,DMA;
//    each ack exactly one cycle, one IDLE cycle between.
//  5 CPU read in progress, change cpu_addr mid-ACC -> mem_addr keeps original;
//    dma_req rises mid-ACC -> DMA served in next grant.
//  6 Assert rst=0 during ACC_DMA (MEM_LAT=3, cycle 2) -> strobes drop same cycle,
//    no dma_ack; after release, last_grant=DMA so CPU wins tie.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported unified memory between the multicycle
//            CPU controller and the DMA/program loader. Round-robin
//            arbitration, address/data capture at grant, a configurable
//            wait-state counter, and a one-cycle ack pulse with registered
//            read data.
// Ports    : clk_i, rst_ni            clock / async active-low reset
//            cpu_req_i, cpu_we_i      CPU request and direction (1 = write)
//            cpu_addr_i, cpu_wdata_i  CPU address / write data
//            cpu_rdata_o, cpu_ack_o   CPU read data (valid with ack) / ack
//            cpu_stall_o              cpu_req_i & ~cpu_ack_o
//            dma_*                    same set for the DMA requester
//            mem_addr_o, mem_wdata_o  registered memory address / write data
//            mem_rd_o, mem_wr_o       memory strobes (never both high)
//            mem_rdata_i              memory read data
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,
  output logic          cpu_stall_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic [DW-1:0] dma_rdata_o,
  output logic          dma_ack_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_rd_o,
  output logic          mem_wr_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int          CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] LAT_ONE  = CW'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACC_CPU = 2'd1;
  localparam logic [1:0] ST_ACC_DMA = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  // Owner encoding shared by last_grant: 0 = CPU, 1 = DMA.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] lat_cnt_q;
  logic          last_grant_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;

  logic w_grant_cpu;
  logic w_grant_dma;
  logic w_in_acc;
  logic w_lat_done;

  // Round-robin: on a tie the requester that did not win last time goes.
  assign w_grant_cpu = cpu_req_i & (~dma_req_i | (last_grant_q == OWN_DMA));
  assign w_grant_dma = dma_req_i & (~cpu_req_i | (last_grant_q == OWN_CPU));

  assign w_in_acc   = (state_q == ST_ACC_CPU) | (state_q == ST_ACC_DMA);
  assign w_lat_done = (lat_cnt_q == '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_grant_cpu) begin
          state_d = ST_ACC_CPU;
        end else if (w_grant_dma) begin
          state_d = ST_ACC_DMA;
        end
      end
      ST_ACC_CPU, ST_ACC_DMA: begin
        if (w_lat_done) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Always return through IDLE so arbitration gets a fresh look.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state so reset drops them at once)
  // --------------------------------------------------------------------------
  always_comb begin
    mem_rd_o  = 1'b0;
    mem_wr_o  = 1'b0;
    cpu_ack_o = 1'b0;
    dma_ack_o = 1'b0;
    unique case (state_q)
      ST_ACC_CPU, ST_ACC_DMA: begin
        mem_rd_o = ~we_q;
        mem_wr_o = we_q;
      end
      ST_ACK: begin
        // last_grant was loaded at the grant edge, so it names the owner.
        cpu_ack_o = (last_grant_q == OWN_CPU);
        dma_ack_o = (last_grant_q == OWN_DMA);
      end
      default: begin
      end
    endcase
  end

  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;

  // --------------------------------------------------------------------------
  // Transfer datapath: request capture, wait-state counter, read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_cnt_q    <= '0;
      last_grant_q <= OWN_DMA;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (w_grant_cpu) begin
          addr_q       <= cpu_addr_i;
          wdata_q      <= cpu_wdata_i;
          we_q         <= cpu_we_i;
          last_grant_q <= OWN_CPU;
          lat_cnt_q    <= LAT_INIT;
        end else if (w_grant_dma) begin
          addr_q       <= dma_addr_i;
          wdata_q      <= dma_wdata_i;
          we_q         <= dma_we_i;
          last_grant_q <= OWN_DMA;
          lat_cnt_q    <= LAT_INIT;
        end
      end else if (w_in_acc) begin
        if (w_lat_done) begin
          // Read data is valid on the final access cycle only.
          if (!we_q) begin
            if (state_q == ST_ACC_CPU) begin
              cpu_rdata_q <= mem_rdata_i;
            end else begin
              dma_rdata_q <= mem_rdata_i;
            end
          end
        end else begin
          lat_cnt_q <= lat_cnt_q - LAT_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter. Two instances
//            share stimulus: u_dut1 (MEM_LAT=1) and u_dut3 (MEM_LAT=3). Each
//            memory returns {000,addr} ^ 8'hA6 on reads.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [4:0] cpu_addr, dma_addr;
  logic [7:0] cpu_wdata, dma_wdata;

  logic [7:0] cpu_rdata1, dma_rdata1, mem_wdata1, mem_rdata1;
  logic       cpu_ack1, cpu_stall1, dma_ack1, mem_rd1, mem_wr1;
  logic [4:0] mem_addr1;
  logic [7:0] cpu_rdata3, dma_rdata3, mem_wdata3, mem_rdata3;
  logic       cpu_ack3, cpu_stall3, dma_ack3, mem_rd3, mem_wr3;
  logic [4:0] mem_addr3;

  int n_vec;
  int n_err;

  int         wr_cnt3;
  logic [4:0] wr_addr3;
  logic [7:0] wr_data3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata1 = {3'b000, mem_addr1} ^ 8'hA6;
  assign mem_rdata3 = {3'b000, mem_addr3} ^ 8'hA6;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt3  <= 0;
      wr_addr3 <= '0;
      wr_data3 <= '0;
    end else if (mem_wr3) begin
      wr_cnt3  <= wr_cnt3 + 1;
      wr_addr3 <= mem_addr3;
      wr_data3 <= mem_wdata3;
    end
  end

  mem_port_arbiter #(.AW(5), .DW(8), .MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata1), .cpu_ack_o(cpu_ack1), .cpu_stall_o(cpu_stall1),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(dma_rdata1), .dma_ack_o(dma_ack1),
    .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1), .mem_rd_o(mem_rd1), .mem_wr_o(mem_wr1),
    .mem_rdata_i(mem_rdata1)
  );

  mem_port_arbiter #(.AW(5), .DW(8), .MEM_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata3), .cpu_ack_o(cpu_ack3), .cpu_stall_o(cpu_stall3),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(dma_rdata3), .dma_ack_o(dma_ack3),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rd_o(mem_rd3), .mem_wr_o(mem_wr3),
    .mem_rdata_i(mem_rdata3)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 5'h01; dma_addr = 5'h02;
    tick();
    tick();
    n_vec++; if (mem_rd1 !== 1'b0 || mem_wr1 !== 1'b0) begin n_err++; $display("FAIL reset_strobes got rd=%b wr=%b exp 0 0", mem_rd1, mem_wr1); end
    n_vec++; if (cpu_ack1 !== 1'b0 || dma_ack1 !== 1'b0) begin n_err++; $display("FAIL reset_acks got cpu=%b dma=%b exp 0 0", cpu_ack1, dma_ack1); end
    n_vec++; if (cpu_stall1 !== 1'b1) begin n_err++; $display("FAIL reset_stall got %b exp 1", cpu_stall1); end
    n_vec++; if (mem_addr1 !== 5'h00 || cpu_rdata1 !== 8'h00) begin n_err++; $display("FAIL reset_regs got addr=%h rdata=%h exp 00 00", mem_addr1, cpu_rdata1); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (mem_rd1 !== 1'b0) begin n_err++; $display("FAIL reset_cyc0_rd got %b exp 0", mem_rd1); end
    tick();
    n_vec++; if (mem_rd1 !== 1'b1 || mem_addr1 !== 5'h01) begin n_err++; $display("FAIL reset_cpu_first got rd=%b addr=%h exp 1 01", mem_rd1, mem_addr1); end
    tick();
    n_vec++; if (cpu_ack1 !== 1'b1 || dma_ack1 !== 1'b0) begin n_err++; $display("FAIL reset_cyc2_ack got cpu=%b dma=%b exp 1 0", cpu_ack1, dma_ack1); end
    n_vec++; if (cpu_stall1 !== 1'b0) begin n_err++; $display("FAIL reset_stall_ack got %b exp 0", cpu_stall1); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_cpu_read;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
    tick();
    n_vec++; if (mem_rd1 !== 1'b1 || mem_wr1 !== 1'b0) begin n_err++; $display("FAIL rd_strobe got rd=%b wr=%b exp 1 0", mem_rd1, mem_wr1); end
    n_vec++; if (mem_addr1 !== 5'h03) begin n_err++; $display("FAIL rd_addr got %h exp 03", mem_addr1); end
    n_vec++; if (cpu_ack1 !== 1'b0) begin n_err++; $display("FAIL rd_early_ack got %b exp 0", cpu_ack1); end
    tick();
    n_vec++; if (cpu_ack1 !== 1'b1 || cpu_rdata1 !== 8'hA5) begin n_err++; $display("FAIL rd_ack_data got ack=%b data=%h exp 1 a5", cpu_ack1, cpu_rdata1); end
    n_vec++; if (mem_rd1 !== 1'b0 || dma_ack1 !== 1'b0) begin n_err++; $display("FAIL rd_ack_side got rd=%b dma_ack=%b exp 0 0", mem_rd1, dma_ack1); end
    cpu_req = 1'b0;
    tick();
    n_vec++; if (cpu_ack1 !== 1'b0 || cpu_rdata1 !== 8'hA5) begin n_err++; $display("FAIL rd_after got ack=%b data=%h exp 0 a5", cpu_ack1, cpu_rdata1); end
    tick();
    n_vec++; if (mem_rd1 !== 1'b0) begin n_err++; $display("FAIL rd_no_regrant got %b exp 0", mem_rd1); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_dma_write;
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'h1F; dma_wdata = 8'h3C;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++; if (mem_wr3 !== 1'b1 || mem_rd3 !== 1'b0) begin n_err++; $display("FAIL wr_strobe_c%0d got wr=%b rd=%b exp 1 0", i, mem_wr3, mem_rd3); end
      n_vec++; if (mem_addr3 !== 5'h1F || mem_wdata3 !== 8'h3C) begin n_err++; $display("FAIL wr_bus_c%0d got addr=%h data=%h exp 1f 3c", i, mem_addr3, mem_wdata3); end
      n_vec++; if (dma_ack3 !== 1'b0 || cpu_stall3 !== 1'b0) begin n_err++; $display("FAIL wr_ack_stall_c%0d got ack=%b stall=%b exp 0 0", i, dma_ack3, cpu_stall3); end
    end
    tick();
    n_vec++; if (dma_ack3 !== 1'b1 || cpu_ack3 !== 1'b0) begin n_err++; $display("FAIL wr_ack got dma=%b cpu=%b exp 1 0", dma_ack3, cpu_ack3); end
    n_vec++; if (mem_wr3 !== 1'b0 || cpu_stall3 !== 1'b0) begin n_err++; $display("FAIL wr_ack_strobe got wr=%b stall=%b exp 0 0", mem_wr3, cpu_stall3); end
    n_vec++; if (wr_cnt3 !== 3 || wr_addr3 !== 5'h1F || wr_data3 !== 8'h3C) begin n_err++; $display("FAIL wr_mem got cnt=%0d addr=%h data=%h exp 3 1f 3c", wr_cnt3, wr_addr3, wr_data3); end
    dma_req = 1'b0;
    tick();
    n_vec++; if (dma_ack3 !== 1'b0) begin n_err++; $display("FAIL wr_ack_pulse got %b exp 0", dma_ack3); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back;
    logic own_dma;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 5'h02;
    dma_req = 1'b1; dma_addr = 5'h04;
    own_dma = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_vec++; if (mem_rd1 !== 1'b1 || mem_addr1 !== (own_dma ? 5'h04 : 5'h02)) begin n_err++; $display("FAIL b2b_grant_%0d got rd=%b addr=%h exp 1 %h", t, mem_rd1, mem_addr1, own_dma ? 5'h04 : 5'h02); end
      tick();
      n_vec++; if (cpu_ack1 !== ~own_dma || dma_ack1 !== own_dma) begin n_err++; $display("FAIL b2b_ack_%0d got cpu=%b dma=%b exp %b %b", t, cpu_ack1, dma_ack1, ~own_dma, own_dma); end
      if (own_dma) begin
        n_vec++; if (dma_rdata1 !== 8'hA2) begin n_err++; $display("FAIL b2b_dma_data_%0d got %h exp a2", t, dma_rdata1); end
      end else begin
        n_vec++; if (cpu_rdata1 !== 8'hA4) begin n_err++; $display("FAIL b2b_cpu_data_%0d got %h exp a4", t, cpu_rdata1); end
      end
      tick();
      n_vec++; if (cpu_ack1 !== 1'b0 || dma_ack1 !== 1'b0 || mem_rd1 !== 1'b0) begin n_err++; $display("FAIL b2b_idle_%0d got cpu=%b dma=%b rd=%b exp 0 0 0", t, cpu_ack1, dma_ack1, mem_rd1); end
      own_dma = ~own_dma;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mid_change;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05;
    tick();
    n_vec++; if (mem_addr3 !== 5'h05) begin n_err++; $display("FAIL mid_addr_c1 got %h exp 05", mem_addr3); end
    cpu_addr = 5'h0A; cpu_we = 1'b1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'h07;
    tick();
    n_vec++; if (mem_addr3 !== 5'h05 || mem_rd3 !== 1'b1) begin n_err++; $display("FAIL mid_addr_c2 got addr=%h rd=%b exp 05 1", mem_addr3, mem_rd3); end
    tick();
    n_vec++; if (mem_addr3 !== 5'h05 || mem_rd3 !== 1'b1 || mem_wr3 !== 1'b0) begin n_err++; $display("FAIL mid_addr_c3 got addr=%h rd=%b wr=%b exp 05 1 0", mem_addr3, mem_rd3, mem_wr3); end
    tick();
    n_vec++; if (cpu_ack3 !== 1'b1 || cpu_rdata3 !== 8'hA3 || dma_ack3 !== 1'b0) begin n_err++; $display("FAIL mid_cpu_ack got ack=%b data=%h dma_ack=%b exp 1 a3 0", cpu_ack3, cpu_rdata3, dma_ack3); end
    tick();
    n_vec++; if (mem_rd3 !== 1'b0 || mem_wr3 !== 1'b0) begin n_err++; $display("FAIL mid_idle got rd=%b wr=%b exp 0 0", mem_rd3, mem_wr3); end
    tick();
    n_vec++; if (mem_addr3 !== 5'h07 || mem_rd3 !== 1'b1) begin n_err++; $display("FAIL mid_dma_grant got addr=%h rd=%b exp 07 1", mem_addr3, mem_rd3); end
    tick();
    tick();
    tick();
    n_vec++; if (dma_ack3 !== 1'b1 || dma_rdata3 !== 8'hA1 || cpu_rdata3 !== 8'hA3) begin n_err++; $display("FAIL mid_dma_ack got ack=%b data=%h cpu_data=%h exp 1 a1 a3", dma_ack3, dma_rdata3, cpu_rdata3); end
    n_vec++; if (cpu_stall3 !== 1'b1) begin n_err++; $display("FAIL mid_cpu_wait got stall=%b exp 1", cpu_stall3); end
    clear_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_access;
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'h10; dma_wdata = 8'h99;
    tick();
    tick();
    n_vec++; if (mem_wr3 !== 1'b1) begin n_err++; $display("FAIL abort_pre got wr=%b exp 1", mem_wr3); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (mem_wr3 !== 1'b0 || mem_rd3 !== 1'b0) begin n_err++; $display("FAIL abort_drop got wr=%b rd=%b exp 0 0", mem_wr3, mem_rd3); end
    tick();
    tick();
    n_vec++; if (dma_ack3 !== 1'b0 || mem_wr3 !== 1'b0) begin n_err++; $display("FAIL abort_no_ack got ack=%b wr=%b exp 0 0", dma_ack3, mem_wr3); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05;
    rst_n = 1'b1;
    tick();
    n_vec++; if (mem_rd3 !== 1'b1 || mem_wr3 !== 1'b0 || mem_addr3 !== 5'h05) begin n_err++; $display("FAIL abort_cpu_wins got rd=%b wr=%b addr=%h exp 1 0 05", mem_rd3, mem_wr3, mem_addr3); end
    clear_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_mid_change();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
